// File: rtl/four_two_encoder_sync_if.sv
// Valid/ready code channel between the encoder and its consumer.
// The master presents Y/valid and the slave answers with ready.
interface four_two_encoder_sync_if;
    logic [1:0] Y;
    logic       valid;
    logic       ready;

    modport master (output Y, output valid, input ready);
    modport slave  (input Y, input valid, output ready);
endinterface

// File: rtl/four_two_encoder_sync.sv
// Sequential 4-to-2 priority encoder. Synchronised request rising edges are
// latched as pending events and emitted one code per valid/ready beat.
module four_two_encoder_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          HIGH_FIRST  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     req,
    four_two_encoder_sync_if.master        bus,
    output logic [3:0]                     pending,
    output logic                           overrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    logic [3:0] req_d_q, req_d_d;
    logic [3:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic [1:0] y_q, y_d;
    logic [3:0] req_s;
    logic [3:0] edge_s;
    logic [3:0] clr;
    logic       xfer;

    function automatic logic [1:0] enc(input logic [3:0] m);
        logic [1:0] r;
        if (HIGH_FIRST)
            r = m[3] ? 2'd3 : m[2] ? 2'd2 : m[1] ? 2'd1 : 2'd0;
        else
            r = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
        return r;
    endfunction

    always_comb begin
        sync_d[0] = req;
        for (int unsigned k = 1; k < SYNC_STAGES; k++)
            sync_d[k] = sync_q[k-1];
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign req_d_d = req_s;
    assign edge_s  = req_s & ~req_d_q;
    assign xfer    = (state_q == SEND) && bus.ready;
    assign clr     = xfer ? (4'b0001 << y_q) : '0;

    // A new edge on a bit being cleared this cycle wins, so the fresh event survives.
    always_comb begin
        pending_d = (pending_q & ~clr) | edge_s;
        overrun_d = overrun_q | (|(edge_s & pending_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= '0;
            req_d_q   <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
            y_q       <= '0;
            state_q   <= IDLE;
        end else begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_d[k];
            req_d_q   <= req_d_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            y_q       <= y_d;
            state_q   <= state_d;
        end
    end

    // Y is captured only on IDLE->SEND, so bits arriving during SEND cannot disturb it.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: if (|pending_q) begin
                y_d     = enc(pending_q);
                state_d = SEND;
            end
            SEND: if (bus.ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.valid = (state_q == SEND);
        bus.Y     = y_q;
        pending   = pending_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_four_two_encoder_sync.sv
// Bench for four_two_encoder_sync: event-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_four_two_encoder_sync;

    localparam int unsigned S  = 2;
    localparam bit          HF = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] pending;
    logic       overrun;

    four_two_encoder_sync_if bus();

    four_two_encoder_sync #(.SYNC_STAGES(S), .HIGH_FIRST(HF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .bus     (bus),
        .pending (pending),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: req history, event set, and the code currently offered.
    bit [3:0] hist[$];
    bit [3:0] m_pend;
    bit       m_ovr;
    bit       m_valid;
    int       m_y;

    function automatic int pick(input bit [3:0] m);
        if (HF) begin
            for (int i = 3; i >= 0; i--) if (m[i]) return i;
        end else begin
            for (int i = 0; i <= 3; i++) if (m[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(4'b0000);
            m_pend = '0; m_ovr = 1'b0; m_valid = 1'b0; m_y = 0;
        end else begin
            bit [3:0] rise, cl;
            rise = hist[S-1] & ~hist[S];
            cl   = (m_valid && bus.ready) ? 4'(1 << m_y) : 4'b0000;
            if ((rise & m_pend & ~cl) != 0) m_ovr = 1'b1;
            if (m_valid) begin
                if (bus.ready) m_valid = 1'b0;
            end else if (m_pend != 0) begin
                m_y     = pick(m_pend);
                m_valid = 1'b1;
            end
            m_pend = (m_pend & ~cl) | rise;
            hist.push_front(req);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("valid",   32'(bus.valid), 32'(m_valid));
            chk("Y",       32'(bus.Y),     32'(m_y));
            chk("pending", 32'(pending),   32'(m_pend));
            chk("overrun", 32'(overrun),   32'(m_ovr));
        end
    end

    int beats[$];
    always @(posedge clk)
        if (rst_n && bus.valid && bus.ready) beats.push_back(int'(bus.Y));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; bus.ready = 1'b0;

        // 1: reset state
        tick(5);
        chk("t1_valid",   32'(bus.valid), 0);
        chk("t1_Y",       32'(bus.Y),     0);
        chk("t1_pending", 32'(pending),   0);
        chk("t1_overrun", 32'(overrun),   0);
        rst_n = 1'b1; chk_en = 1'b1;

        // 2: single request latency
        req = 4'b0100; bus.ready = 1'b1;
        tick(3);
        chk("t2_pend_e3",  32'(pending),   32'h4);
        chk("t2_valid_e3", 32'(bus.valid), 0);
        tick(1);
        chk("t2_valid_e4", 32'(bus.valid), 1);
        chk("t2_Y_e4",     32'(bus.Y),     2);
        tick(1);
        chk("t2_valid_e5", 32'(bus.valid), 0);
        chk("t2_pend_e5",  32'(pending),   0);
        req = 4'b0000; tick(6);

        // 3: two simultaneous edges, priority order 2 clocks apart
        req = 4'b1010;
        tick(4);
        chk("t3_valid_a", 32'(bus.valid), 1);
        chk("t3_Y_a",     32'(bus.Y),     3);
        tick(1);
        chk("t3_gap",     32'(bus.valid), 0);
        tick(1);
        chk("t3_valid_b", 32'(bus.valid), 1);
        chk("t3_Y_b",     32'(bus.Y),     1);
        tick(1);
        chk("t3_done",    32'(bus.valid), 0);
        req = 4'b0000; tick(6);

        // 4: back-pressure, then a duplicate edge merges and flags overrun
        bus.ready = 1'b0; req = 4'b0001;
        tick(4);
        chk("t4_valid", 32'(bus.valid), 1);
        chk("t4_Y",     32'(bus.Y),     0);
        tick(10);
        chk("t4_hold_valid", 32'(bus.valid), 1);
        chk("t4_hold_Y",     32'(bus.Y),     0);
        req = 4'b0000; tick(3);
        req = 4'b0001; tick(4);
        chk("t4_overrun", 32'(overrun), 1);
        chk("t4_pending", 32'(pending), 32'h1);
        beats.delete();
        bus.ready = 1'b1; tick(6);
        chk("t4_beats",  32'(beats.size()), 1);
        if (beats.size() > 0) chk("t4_beat_Y", 32'(beats[0]), 0);

        // 5: async reset mid-SEND
        req = 4'b0000; bus.ready = 1'b0; tick(3);
        req = 4'b0010;
        for (int i = 0; i < 10 && !bus.valid; i++) tick(1);
        chk("t5_valid_wait", 32'(bus.valid), 1);
        chk("t5_ovr_before", 32'(overrun),   1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid",   32'(bus.valid), 0);
        chk("t5_pending", 32'(pending),   0);
        chk("t5_overrun", 32'(overrun),   0);
        req = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // 6: all four held high -> exactly four beats in priority order
        bus.ready = 1'b1; beats.delete();
        req = 4'b1111;
        tick(20);
        chk("t6_beats", 32'(beats.size()), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++)
            chk($sformatf("t6_beat%0d", i), 32'(beats[i]), 32'(3 - i));
        chk("t6_valid",   32'(bus.valid), 0);
        chk("t6_pending", 32'(pending),   0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
